// File: rtl/i2c_target_multi.sv
// I2C register target answering to a primary address plus up to N_ALIAS enabled alias addresses.
// Latency: a pin change reaches the FSM after SYNC_STAGES+1 clk_i cycles; wr_en_o follows the 8th data-bit SCL rise by that delay.
// Backpressure: none; the bus host paces everything, wr_en_o must be taken as issued and rd_data_i must answer rd_addr_o combinationally.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   own_addr_i               primary 7-bit target address
//   alias_addr_i, alias_en_i alias address k in bits [7k+6:7k], enabled by alias_en_i[k]
//   auto_inc_i               advance the register pointer after each write / host-ACKed read
//   scl_i, sda_io            I2C bus; sda_io is only ever pulled low or released
//   wr_addr_o, wr_data_o,
//   wr_en_o                  register write port, one-cycle strobe, address/data held between strobes
//   rd_addr_o, rd_data_i     register read port, rd_addr_o is the current pointer
//   busy_o                   set on address match, cleared by STOP, NACK or a non-matching address
module i2c_target_multi #(
  parameter int NUM_REGS    = 256,
  parameter int N_ALIAS     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [6:0]           own_addr_i,
  input  logic [7*N_ALIAS-1:0] alias_addr_i,
  input  logic [N_ALIAS-1:0]   alias_en_i,
  input  logic                 auto_inc_i,
  input  logic                 scl_i,
  inout  wire                  sda_io,
  output logic [7:0]           wr_addr_o,
  output logic [7:0]           wr_data_o,
  output logic                 wr_en_o,
  output logic [7:0]           rd_addr_o,
  input  logic [7:0]           rd_data_i,
  output logic                 busy_o
);

  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [7:0] PTR_MAX    = 8'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  // Bus synchronizers plus one extra sample for edge detection.
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_io};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  logic start_det, stop_det, scl_rise, scl_fall;
  assign start_det = scl_s && scl_d && sda_d && !sda_s;
  assign stop_det  = scl_s && scl_d && !sda_d && sda_s;
  assign scl_rise  = scl_s && !scl_d;
  assign scl_fall  = !scl_s && scl_d;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;      // bit index; in *_ACK states 0/1 marks before/after the ACK is driven
  logic [6:0] shift_q, shift_d;  // first seven received bits of the current byte
  logic [6:0] tx_q, tx_d;        // remaining bits of the byte being read out
  logic       oe_q, oe_d;        // 1 pulls SDA low
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       busy_d, wr_en_d;
  logic [7:0] wr_addr_d, wr_data_d;

  logic [7:0] rx_byte, ptr_inc;
  logic       addr_match;

  assign rx_byte = {shift_q, sda_s};
  assign ptr_inc = !auto_inc_i ? ptr_q : (ptr_q == PTR_MAX) ? 8'd0 : ptr_q + 8'd1;

  always_comb begin
    addr_match = (shift_q == own_addr_i);
    for (int k = 0; k < N_ALIAS; k++) begin
      if (alias_en_i[k] && (alias_addr_i[7*k +: 7] == shift_q)) addr_match = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    oe_d      = oe_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    busy_d    = busy_o;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_o;
    wr_data_d = wr_data_o;

    if (stop_det) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = ADDR;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = rx_byte[6:0];
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            // shift_q already holds the 7 address bits; sda_s is R/W.
            cnt_d  = 3'd0;
            rw_d   = sda_s;
            busy_d = addr_match;
            state_d = addr_match ? ADDR_ACK : IDLE;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (cnt_q == 3'd0) begin
            oe_d  = 1'b1;
            cnt_d = 3'd1;
          end else begin
            cnt_d = 3'd0;
            if (rw_q) begin
              // This falling edge opens the first read byte.
              state_d = RDATA;
              tx_d    = rd_data_i[6:0];
              oe_d    = ~rd_data_i[7];
            end else begin
              state_d = PTR;
              oe_d    = 1'b0;
            end
          end
        end
        PTR: if (scl_rise) begin
          shift_d = rx_byte[6:0];
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            cnt_d = 3'd0;
            if ({1'b0, rx_byte} < NUM_REGS_W) begin
              ptr_d   = rx_byte;
              state_d = PTR_ACK;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (cnt_q == 3'd0) begin
            oe_d  = 1'b1;
            cnt_d = 3'd1;
          end else begin
            oe_d    = 1'b0;
            cnt_d   = 3'd0;
            state_d = WDATA;
          end
        end
        WDATA: if (scl_rise) begin
          shift_d = rx_byte[6:0];
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            cnt_d     = 3'd0;
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = rx_byte;
            ptr_d     = ptr_inc;
            state_d   = WDATA_ACK;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              cnt_d   = 3'd0;
              state_d = RDATA_ACK;
            end
          end else if (scl_fall) begin
            oe_d = ~tx_q[6];
            tx_d = {tx_q[5:0], 1'b0};
          end
        end
        RDATA_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              oe_d = 1'b0;
            end else begin
              // Host ACKed: this falling edge opens the next byte at the advanced pointer.
              state_d = RDATA;
              cnt_d   = 3'd0;
              tx_d    = rd_data_i[6:0];
              oe_d    = ~rd_data_i[7];
            end
          end else if (scl_rise && cnt_q == 3'd0) begin
            if (sda_s) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              ptr_d = ptr_inc;
              cnt_d = 3'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      shift_q   <= 7'd0;
      tx_q      <= 7'd0;
      oe_q      <= 1'b0;
      ptr_q     <= 8'd0;
      rw_q      <= 1'b0;
      busy_o    <= 1'b0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= 8'd0;
      wr_data_o <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      oe_q      <= oe_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      busy_o    <= busy_d;
      wr_en_o   <= wr_en_d;
      wr_addr_o <= wr_addr_d;
      wr_data_o <= wr_data_d;
    end
  end

  assign rd_addr_o = ptr_q;
  assign sda_io    = oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_target_multi.sv
// Directed bench for i2c_target_multi: a bit-banged host drives the bus, writes are logged from wr_en.
// Latency: host quarter-bit is Q clk cycles, far above the synchronizer delay.
// Backpressure: none; register file modelled as rd_data = rd_addr + 0x80.
module tb_i2c_target_multi;

  localparam int Q = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [6:0]  own_addr;
  logic [27:0] alias_addr;
  logic [3:0]  alias_en;
  logic        auto_inc;
  logic        scl;
  logic        host_low;
  wire         sda;
  logic [7:0]  wr_addr, wr_data, rd_addr, rd_data;
  logic        wr_en, busy;

  assign sda = host_low ? 1'b0 : 1'bz;
  pullup (sda);
  assign rd_data = rd_addr + 8'h80;

  i2c_target_multi #(
    .NUM_REGS   (16),
    .N_ALIAS    (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .own_addr_i  (own_addr),
    .alias_addr_i(alias_addr),
    .alias_en_i  (alias_en),
    .auto_inc_i  (auto_inc),
    .scl_i       (scl),
    .sda_io      (sda),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .wr_en_o     (wr_en),
    .rd_addr_o   (rd_addr),
    .rd_data_i   (rd_data),
    .busy_o      (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] wr_q[$];

  always @(negedge clk) if (wr_en) wr_q.push_back({wr_addr, wr_data});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  // One SCL clock: host puts b on SDA (1 = release), returns SDA sampled while SCL is high.
  task automatic bit_clk(input logic b, output logic s);
    host_low = ~b;
    qwait();
    scl = 1'b1;
    qwait();
    s = sda;
    scl = 1'b0;
    qwait();
  endtask

  task automatic i2c_start();
    host_low = 1'b0;
    qwait();
    scl = 1'b1;
    qwait();
    host_low = 1'b1;
    qwait();
    scl = 1'b0;
    qwait();
  endtask

  task automatic i2c_stop();
    host_low = 1'b1;
    qwait();
    scl = 1'b1;
    qwait();
    host_low = 1'b0;
    qwait();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) bit_clk(b[i], d);
    bit_clk(1'b1, ack);
  endtask

  task automatic send_bits4(input logic [3:0] v);
    logic d;
    for (int i = 3; i >= 0; i--) bit_clk(v[i], d);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    logic d;
    logic [7:0] t;
    t = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      bit_clk(1'b1, d);
      t[i] = d;
    end
    bit_clk(nack, d);
    b = t;
  endtask

  // START, address 0x40/W, pointer byte; both acknowledgements checked against exp_ptr_ack.
  task automatic addr_ptr(input string tag, input logic [7:0] ptr, input logic exp_ptr_ack);
    logic ack;
    i2c_start();
    write_byte(8'h80, ack);
    chk({tag, "_addr_ack"}, 32'(ack), 32'd0);
    write_byte(ptr, ack);
    chk({tag, "_ptr_ack"}, 32'(ack), 32'(exp_ptr_ack));
  endtask

  task automatic check_wr(input string tag, input int n, input logic [15:0] e0, input logic [15:0] e1);
    chk({tag, "_nwr"}, 32'(wr_q.size()), 32'(n));
    if (n > 0 && wr_q.size() > 0) chk({tag, "_wr0"}, 32'(wr_q[0]), 32'(e0));
    if (n > 1 && wr_q.size() > 1) chk({tag, "_wr1"}, 32'(wr_q[1]), 32'(e1));
    wr_q.delete();
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;

    rst_n      = 1'b0;
    own_addr   = 7'h40;
    alias_addr = 28'h0;
    alias_addr[13:7] = 7'h70;
    alias_en   = 4'b0000;
    auto_inc   = 1'b1;
    scl        = 1'b1;
    host_low   = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_wr_en",   32'(wr_en),   32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_ptr",     32'(rd_addr), 32'd0);
    chk("rst_sda",     32'(sda),     32'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Two auto-incremented writes from pointer 0x06.
    addr_ptr("wr1", 8'h06, 1'b0);
    chk("wr1_busy", 32'(busy), 32'd1);
    write_byte(8'hA5, ack);
    chk("wr1_d0_ack", 32'(ack), 32'd0);
    write_byte(8'h5A, ack);
    chk("wr1_d1_ack", 32'(ack), 32'd0);
    i2c_stop();
    chk("wr1_busy_stop", 32'(busy), 32'd0);
    chk("wr1_ptr", 32'(rd_addr), 32'h08);
    chk("wr1_hold_addr", 32'(wr_addr), 32'h07);
    chk("wr1_hold_data", 32'(wr_data), 32'h5A);
    check_wr("wr1", 2, 16'h06A5, 16'h075A);

    // Pointer wraps from NUM_REGS-1 to 0.
    addr_ptr("wrap", 8'h0F, 1'b0);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    i2c_stop();
    chk("wrap_ptr", 32'(rd_addr), 32'h01);
    check_wr("wrap", 2, 16'h0F11, 16'h0022);

    // auto_inc off: both writes land on the same register.
    auto_inc = 1'b0;
    addr_ptr("noinc", 8'h04, 1'b0);
    write_byte(8'h10, ack);
    write_byte(8'h20, ack);
    i2c_stop();
    chk("noinc_ptr", 32'(rd_addr), 32'h04);
    check_wr("noinc", 2, 16'h0410, 16'h0420);
    auto_inc = 1'b1;

    // Set pointer, repeated START, read three bytes ending with NACK.
    addr_ptr("rd", 8'h03, 1'b0);
    i2c_start();
    write_byte(8'h81, ack);
    chk("rd_addr_ack", 32'(ack), 32'd0);
    read_byte(rb, 1'b0);
    chk("rd_b0", 32'(rb), 32'h83);
    read_byte(rb, 1'b0);
    chk("rd_b1", 32'(rb), 32'h84);
    read_byte(rb, 1'b1);
    chk("rd_b2", 32'(rb), 32'h85);
    chk("rd_busy_nack", 32'(busy), 32'd0);
    chk("rd_sda_rel", 32'(sda), 32'd1);
    i2c_stop();
    chk("rd_ptr_persist", 32'(rd_addr), 32'h05);
    check_wr("rd", 0, 16'h0, 16'h0);

    // Alias 1 = 0x70: ignored while disabled, answered when enabled.
    i2c_start();
    write_byte(8'hE0, ack);
    chk("alias_off_ack", 32'(ack), 32'd1);
    chk("alias_off_busy", 32'(busy), 32'd0);
    i2c_stop();
    alias_en = 4'b0010;
    i2c_start();
    write_byte(8'hE0, ack);
    chk("alias_on_ack", 32'(ack), 32'd0);
    chk("alias_on_busy", 32'(busy), 32'd1);
    i2c_start();
    write_byte(8'h22, ack);
    chk("nomatch_ack", 32'(ack), 32'd1);
    chk("nomatch_busy", 32'(busy), 32'd0);
    i2c_stop();

    // Out-of-range pointer: NACK, pointer kept, following byte ignored.
    addr_ptr("badptr", 8'h20, 1'b1);
    chk("badptr_busy", 32'(busy), 32'd0);
    write_byte(8'h99, ack);
    chk("badptr_data_ack", 32'(ack), 32'd1);
    i2c_stop();
    chk("badptr_ptr", 32'(rd_addr), 32'h05);
    check_wr("badptr", 0, 16'h0, 16'h0);

    // STOP after half a data byte.
    addr_ptr("part", 8'h02, 1'b0);
    send_bits4(4'hC);
    i2c_stop();
    chk("part_busy", 32'(busy), 32'd0);
    chk("part_sda", 32'(sda), 32'd1);
    chk("part_ptr", 32'(rd_addr), 32'h02);
    check_wr("part", 0, 16'h0, 16'h0);

    // Reset in the middle of a data byte.
    addr_ptr("mrst", 8'h09, 1'b0);
    chk("mrst_ptr_pre", 32'(rd_addr), 32'h09);
    send_bits4(4'h5);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ptr", 32'(rd_addr), 32'h00);
    chk("mrst_wr_addr", 32'(wr_addr), 32'h00);
    send_bits4(4'hA);
    bit_clk(1'b1, ack);
    chk("mrst_ack", 32'(ack), 32'd1);
    chk("mrst_sda", 32'(sda), 32'd1);
    i2c_stop();
    check_wr("mrst", 0, 16'h0, 16'h0);

    // Recovery after reset.
    addr_ptr("recov", 8'h01, 1'b0);
    write_byte(8'h3C, ack);
    chk("recov_d_ack", 32'(ack), 32'd0);
    i2c_stop();
    repeat (20) @(negedge clk);
    chk("recov_hold_addr", 32'(wr_addr), 32'h01);
    chk("recov_hold_data", 32'(wr_data), 32'h3C);
    check_wr("recov", 1, 16'h013C, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
